// File: rtl/aes_pkg.sv
// Shared AES constants, InvSubBytes FSM state type and S-box lookup tables.
// The forward SBOX table is only built when SUBBYTES_FWD_MODE_EN is defined.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

`ifdef SUBBYTES_FWD_MODE_EN
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
`endif

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational 8-bit inverse S-box lookup.
// With SUBBYTES_FWD_MODE_EN, i_fwd=1 selects the forward S-box instead.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] i_byte,
`ifdef SUBBYTES_FWD_MODE_EN
  input  logic                  i_fwd,
`endif
  output logic [AES_BYTE_W-1:0] o_byte
);

`ifdef SUBBYTES_FWD_MODE_EN
  assign o_byte = i_fwd ? SBOX[i_byte] : INV_SBOX[i_byte];
`else
  assign o_byte = INV_SBOX[i_byte];
`endif

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: BYTES_PER_CYCLE S-box lookups per clock over a 128-bit block.
// SUBBYTES_FWD_MODE_EN adds a `mode` input selecting the forward S-box per block.
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef SUBBYTES_FWD_MODE_EN
  input  logic                   mode,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   busy
);

  localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int BPC_SH    = $clog2(BYTES_PER_CYCLE);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

  // state | meaning: IDLE waits for a block | BUSY substitutes one slice per cycle | DONE holds result
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [AES_BLOCK_W-1:0] r_data;
  logic [AES_BLOCK_W-1:0] w_data_nxt;
  logic [3:0]             w_base;
  logic [AES_BYTE_W-1:0]  w_sb_in  [BYTES_PER_CYCLE];
  logic [AES_BYTE_W-1:0]  w_sb_out [BYTES_PER_CYCLE];
`ifdef SUBBYTES_FWD_MODE_EN
  logic                   r_mode;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)             w_state_nxt = BUSY;
      BUSY:    if (r_cnt == LAST_STEP)   w_state_nxt = DONE;
      DONE:    if (out_ready)            w_state_nxt = IDLE;
      default:                           w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  assign out_data = r_data;

  // First byte of the slice handled this step; byte 0 sits in the MSBs.
  assign w_base = 4'(r_cnt) << BPC_SH;

  always_comb begin
    for (int j = 0; j < BYTES_PER_CYCLE; j++)
      w_sb_in[j] = r_data[AES_BLOCK_W-1-AES_BYTE_W*(int'(w_base)+j) -: AES_BYTE_W];
  end

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .i_byte (w_sb_in[g]),
`ifdef SUBBYTES_FWD_MODE_EN
      .i_fwd  (r_mode),
`endif
      .o_byte (w_sb_out[g])
    );
  end

  always_comb begin
    w_data_nxt = r_data;
    for (int j = 0; j < BYTES_PER_CYCLE; j++)
      w_data_nxt[AES_BLOCK_W-1-AES_BYTE_W*(int'(w_base)+j) -: AES_BYTE_W] = w_sb_out[j];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_data <= '0;
`ifdef SUBBYTES_FWD_MODE_EN
      r_mode <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data <= in_data;
            r_cnt  <= '0;
`ifdef SUBBYTES_FWD_MODE_EN
            r_mode <= mode;
`endif
          end
        end
        BUSY: begin
          r_data <= w_data_nxt;
          r_cnt  <= (r_cnt == LAST_STEP) ? '0 : r_cnt + 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Scoreboard bench for inv_sub_bytes_iter: one instance per legal BYTES_PER_CYCLE, shared stimulus.
// Reference S-boxes are derived from GF(2^8) inversion and the AES affine map.
`timescale 1ns/1ps
module tb_inv_sub_bytes_iter;
  localparam int NL = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic         mode;
  logic [127:0] in_data;
  logic [NL-1:0] in_ready_v, out_valid_v, busy_v;
  logic [127:0] out_data_v [NL];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rd_v [NL];
  logic [127:0] exp_q [$];
  int           acc_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] m_inv(input logic [7:0] b);
    return ginv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] m_fwd(input logic [7:0] b);
    logic [7:0] x;
    x = ginv(b);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic m);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = m ? m_fwd(d[127-8*i -: 8]) : m_inv(d[127-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- DUTs and per-lane monitors ----------------
  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int B  = 1 << g;
    localparam int NS = 16 / B;

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(B)) u_dut (
      .clk       (clk),
      .rst       (rst),
`ifdef SUBBYTES_FWD_MODE_EN
      .mode      (mode),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[g]),
      .in_data   (in_data),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready),
      .out_data  (out_data_v[g]),
      .busy      (busy_v[g])
    );

    initial begin : mon
      logic prev_v, prev_hs;
      prev_v = 1'b0; prev_hs = 1'b0; rd_v[g] = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          rd_v[g] = exp_q.size();
          prev_v = 1'b0; prev_hs = 1'b0;
        end else begin
          if (prev_hs)
            chk($sformatf("idle_after_accept_bpc%0d", B), {126'd0, in_ready_v[g], out_valid_v[g]}, 128'd2);
          prev_hs = 1'b0;
          if (out_valid_v[g]) begin
            if (rd_v[g] >= exp_q.size()) begin
              n_tests++; n_fail++;
              $display("FAIL spurious_out_valid_bpc%0d: got 1 expected 0", B);
            end else begin
              chk($sformatf("data_bpc%0d_blk%0d", B, rd_v[g]), out_data_v[g], exp_q[rd_v[g]]);
              if (!prev_v)
                chk($sformatf("latency_bpc%0d_blk%0d", B, rd_v[g]), 128'(cyc), 128'(acc_q[rd_v[g]] + NS));
              chk($sformatf("done_flags_bpc%0d", B), {126'd0, in_ready_v[g], busy_v[g]}, 128'd1);
              if (out_ready) begin
                rd_v[g]++;
                prev_hs = 1'b1;
              end
            end
          end
          prev_v = out_valid_v[g] && !out_ready;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(&in_ready_v) && n < 200) begin tick(); n++; end
    if (!(&in_ready_v)) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: in_ready %b expected %b", in_ready_v, {NL{1'b1}});
    end
  endtask

  task automatic junk_inputs(input bit force_valid);
    in_valid = force_valid ? 1'b1 : 1'($urandom_range(0, 1));
    in_data  = rnd128();
    mode     = 1'($urandom_range(0, 1));
  endtask

  // Issue one block; bp>0 holds out_ready low for bp cycles after every lane is DONE.
  task automatic run_block(input logic [127:0] d, input logic m, input logic [127:0] expv,
                           input int bp, input bit junk);
    int n;
    wait_idle();
    in_valid = 1'b1; in_data = d; mode = m; out_ready = 1'b1;
    exp_q.push_back(expv);
    acc_q.push_back(cyc + 1);
    tick();
    // every lane is in BUSY for this cycle, so out_ready=1 here must be ignored
    if (junk) junk_inputs(1'b0); else in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    if (bp > 0) begin
      out_ready = 1'b0;
      n = 0;
      while (!(&out_valid_v) && n < 40) begin
        if (junk) junk_inputs(1'b0);
        tick(); n++;
      end
      if (!(&out_valid_v)) begin
        n_tests++; n_fail++;
        $display("FAIL done_timeout: out_valid %b expected %b", out_valid_v, {NL{1'b1}});
      end
      for (int i = 0; i < bp; i++) begin
        junk_inputs(1'b1);
        tick();
      end
      out_ready = 1'b1;
    end
    in_valid = 1'b0;
    if (junk) in_data = rnd128();
  endtask

  task automatic reset_mid();
    logic [127:0] d;
    wait_idle();
    d = rnd128();
    in_valid = 1'b1; in_data = d; mode = 1'b0; out_ready = 1'b1;
    exp_q.push_back(model(d, 1'b0));
    acc_q.push_back(cyc + 1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("rst_pre_busy_bpc4", {127'd0, busy_v[2]}, 128'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_out_valid", {123'd0, out_valid_v}, 128'd0);
    chk("rst_async_in_ready", {123'd0, in_ready_v}, {123'd0, {NL{1'b1}}});
    chk("rst_async_busy", {123'd0, busy_v}, 128'd0);
    chk("rst_async_data_bpc4", out_data_v[2], 128'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [127:0] x, y;
    int bp;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; in_data = '0;
    tick(); tick();
    chk("reset_in_ready", {123'd0, in_ready_v}, {123'd0, {NL{1'b1}}});
    chk("reset_out_valid", {123'd0, out_valid_v}, 128'd0);
    chk("reset_busy", {123'd0, busy_v}, 128'd0);
    for (int i = 0; i < NL; i++) chk($sformatf("reset_data_lane%0d", i), out_data_v[i], 128'd0);
    rst = 1'b0;
    tick();

    run_block(128'hD4E0B81E27BFB44111985D52AEF1E530, 1'b0,
              128'h19A09AE93DF4C6F8E3E28D48BE2B2A08, 0, 1'b0);
    run_block({16{8'h00}}, 1'b0, {16{8'h52}}, 0, 1'b0);
    run_block({16{8'h63}}, 1'b0, {16{8'h00}}, 0, 1'b0);
    run_block({16{8'hFF}}, 1'b0, {16{8'h7D}}, 0, 1'b0);

    x = rnd128();
    run_block(x, 1'b0, model(x, 1'b0), 10, 1'b0);
    x = rnd128();
    run_block(x, 1'b0, model(x, 1'b0), 0, 1'b1);
    x = rnd128();
    run_block(x, 1'b0, model(x, 1'b0), 3, 1'b1);

    reset_mid();
    x = rnd128();
    run_block(x, 1'b0, model(x, 1'b0), 0, 1'b0);

`ifdef SUBBYTES_FWD_MODE_EN
    run_block(128'h19A09AE93DF4C6F8E3E28D48BE2B2A08, 1'b1,
              128'hD4E0B81E27BFB44111985D52AEF1E530, 0, 1'b0);
    x = rnd128();
    y = model(x, 1'b1);
    run_block(x, 1'b1, y, 0, 1'b0);
    run_block(y, 1'b0, x, 2, 1'b1);
`endif

    for (int i = 0; i < 12; i++) begin
      x = rnd128();
`ifdef SUBBYTES_FWD_MODE_EN
      y[0] = 1'($urandom_range(0, 1));
`else
      y[0] = 1'b0;
`endif
      bp = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
      run_block(x, y[0], model(x, y[0]), bp, 1'($urandom_range(0, 1)));
    end

    wait_idle();
    @(negedge clk);
    for (int i = 0; i < NL; i++)
      chk($sformatf("delivered_count_lane%0d", i), 128'(rd_v[i]), 128'(exp_q.size()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
